// File: rtl/mem_arbiter.sv
// Two-port block-RAM arbiter: port 0 has fixed priority, port 1 is guaranteed a slot
// after MAX_WAIT consecutive denied cycles. Read data returns one cycle after the grant.
module mem_arbiter #(
    parameter int AW       = 10,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    input  logic [DW-1:0] mem_dout
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    logic [3:0] starve_cnt;
    logic       rvalid0_q;
    logic       rvalid1_q;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (req1 && (!req0 || (starve_cnt >= MAX_CNT))) begin
                gnt1 = 1'b1;
            end else if (req0) begin
                gnt0 = 1'b1;
            end
        end
    end

    always_comb begin
        mem_addr = '0;
        mem_din  = '0;
        mem_we   = 1'b0;
        if (gnt0) begin
            mem_addr = addr0;
            mem_din  = wdata0;
            mem_we   = we0;
        end else if (gnt1) begin
            mem_addr = addr1;
            mem_din  = wdata1;
            mem_we   = we1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!req1 || gnt1) begin
            starve_cnt <= '0;
        end else if (starve_cnt < MAX_CNT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= gnt0 & ~we0;
            rvalid1_q <= gnt1 & ~we1;
        end
    end

    // Masking with rst drops the response of a read granted just before reset asserts.
    assign rvalid0 = rvalid0_q & ~rst;
    assign rvalid1 = rvalid1_q & ~rst;
    assign rdata   = mem_dout;

endmodule
